// File: rtl/lfsr_pkg.sv
// Shared encodings and default polynomial constants for the parameterised LFSR.
package lfsr_pkg;

  typedef enum logic {
    MODE_FIB = 1'b0,
    MODE_GAL = 1'b1
  } lfsr_mode_e;

  // Maximal-length masks (bit i selects q[i]) and nonzero seeds for common widths.
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [7:0]  SEED_W8  = 8'h01;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [15:0] SEED_W16 = 16'h0001;

endpackage

// File: rtl/lfsr_next.sv
// Pure combinational next-state and serial-output function for one LFSR step.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_W8)
) (
  input  logic [WIDTH-1:0] q,
  input  logic             mode,
  output logic [WIDTH-1:0] q_next,
  output logic             sout
);

  lfsr_mode_e modeSel;
  logic       fibFeedback;

  assign modeSel     = lfsr_mode_e'(mode);
  assign fibFeedback = ^(q & TAPS);

  // Fibonacci shifts left and emits the MSB; Galois shifts right and emits the LSB.
  always_comb begin
    q_next = q;
    sout   = 1'b0;
    if (modeSel == MODE_GAL) begin
      q_next = (q >> 1) ^ (q[0] ? TAPS : '0);
      sout   = q[0];
    end else begin
      q_next = {q[WIDTH-2:0], fibFeedback};
      sout   = q[WIDTH-1];
    end
  end

endmodule

// File: rtl/lfsr_param.sv
// Parameterised Fibonacci/Galois LFSR with load, lockup recovery and period measurement.
module lfsr_param
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_W8),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(SEED_W8),
  parameter int unsigned      CW    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] R,
  input  logic             L,
  input  logic             E,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             lockup,
  output logic             wrap,
  output logic [CW-1:0]    period
);

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] refVal_q, refVal_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    period_q, period_d;
  logic             lockup_q, lockup_d;
  logic             wrap_q, wrap_d;
  lfsr_mode_e       mode_q;
  lfsr_mode_e       modeNow;

  logic [WIDTH-1:0] stepVal;
  logic [WIDTH-1:0] refBase;
  logic [CW-1:0]    cntBase;
  logic [CW-1:0]    cntSat;
  logic             modeChange;

  assign modeNow    = lfsr_mode_e'(mode);
  assign modeChange = (modeNow != mode_q);

  lfsr_next #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_next (
    .q      (lfsr_q),
    .mode   (mode),
    .q_next (stepVal),
    .sout   (sout)
  );

  // A mode switch re-references the cycle at the current state before the
  // step (if any) is taken, so the step on that edge counts toward the new cycle.
  always_comb begin
    lfsr_d   = lfsr_q;
    refVal_d = refVal_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    lockup_d = 1'b0;
    wrap_d   = 1'b0;
    refBase  = refVal_q;
    cntBase  = cnt_q;
    cntSat   = cnt_q;
    if (L) begin
      lfsr_d   = R;
      refVal_d = R;
      cnt_d    = '0;
    end else begin
      if (modeChange) begin
        refBase = lfsr_q;
        cntBase = '0;
      end
      cntSat   = (cntBase == '1) ? cntBase : cntBase + CW'(1);
      refVal_d = refBase;
      cnt_d    = cntBase;
      if (E) begin
        if (lfsr_q == '0) begin
          lfsr_d   = SEED;
          refVal_d = SEED;
          cnt_d    = '0;
          lockup_d = 1'b1;
        end else begin
          lfsr_d = stepVal;
          if (stepVal == refBase) begin
            wrap_d   = 1'b1;
            period_d = cntSat;
            cnt_d    = '0;
          end else begin
            cnt_d = cntSat;
          end
        end
      end
    end
  end

  // Reset also discards any pulse that would have been raised on this edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q   <= SEED;
      refVal_q <= SEED;
      cnt_q    <= '0;
      period_q <= '0;
      lockup_q <= 1'b0;
      wrap_q   <= 1'b0;
      mode_q   <= modeNow;
    end else begin
      lfsr_q   <= lfsr_d;
      refVal_q <= refVal_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      lockup_q <= lockup_d;
      wrap_q   <= wrap_d;
      mode_q   <= modeNow;
    end
  end

  assign q      = lfsr_q;
  assign lockup = lockup_q;
  assign wrap   = wrap_q;
  assign period = period_q;

endmodule

// File: tb/tb_lfsr_param.sv
// Randomised and directed checks of lfsr_param against a behavioural sequence model.
module tb_lfsr_param;

  localparam logic [7:0] TAPS = 8'hB8;
  localparam logic [7:0] SEED = 8'h01;

  logic        clock;
  logic        reset;
  logic [7:0]  R;
  logic        L;
  logic        E;
  logic        mode;
  logic [7:0]  q;
  logic        sout;
  logic        lockup;
  logic        wrap;
  logic [15:0] period;

  int total = 0;
  int bad   = 0;

  // model state
  logic [7:0] mq;
  logic [7:0] mref;
  int         mcnt;
  int         mper;
  logic       mlock;
  logic       mwrap;
  logic       mprev;

  lfsr_param dut (
    .clock  (clock),
    .reset  (reset),
    .R      (R),
    .L      (L),
    .E      (E),
    .mode   (mode),
    .q      (q),
    .sout   (sout),
    .lockup (lockup),
    .wrap   (wrap),
    .period (period)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] refNext(input logic [7:0] v, input logic md);
    int fb;
    if (md) return (v >> 1) ^ ((v % 2 == 1) ? TAPS : 8'h00);
    fb = $countones(v & TAPS) % 2;
    return 8'((v << 1) | fb);
  endfunction

  function automatic void modelEdge(input logic rst, input logic l, input logic e,
                                    input logic md, input logic [7:0] r);
    logic       nl;
    logic       nw;
    logic [7:0] nxt;
    nl = 1'b0;
    nw = 1'b0;
    if (rst) begin
      mq   = SEED;
      mref = SEED;
      mcnt = 0;
      mper = 0;
    end else if (l) begin
      mq   = r;
      mref = r;
      mcnt = 0;
    end else begin
      if (md != mprev) begin
        mref = mq;
        mcnt = 0;
      end
      if (e) begin
        if (mq == 8'h00) begin
          mq   = SEED;
          mref = SEED;
          mcnt = 0;
          nl   = 1'b1;
        end else begin
          nxt = refNext(mq, md);
          mq  = nxt;
          if (nxt == mref) begin
            nw   = 1'b1;
            mper = (mcnt + 1 > 65535) ? 65535 : mcnt + 1;
            mcnt = 0;
          end else begin
            mcnt = (mcnt + 1 > 65535) ? 65535 : mcnt + 1;
          end
        end
      end
    end
    mprev = md;
    mlock = nl;
    mwrap = nw;
  endfunction

  task automatic tick(input logic rst, input logic l, input logic e,
                      input logic md, input logic [7:0] r);
    reset = rst;
    L     = l;
    E     = e;
    mode  = md;
    R     = r;
    modelEdge(rst, l, e, md, r);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h5A);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 8'hC3);
    total++; if (q !== 8'h01) begin bad++; $display("[TB] FAIL reset_q got=%h want=01", q); end
    total++; if (period !== 16'd0) begin bad++; $display("[TB] FAIL reset_period got=%0d want=0", period); end
    total++; if (lockup !== 1'b0 || wrap !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_pulses got lockup=%b wrap=%b want=0/0", lockup, wrap);
    end
    total++; if (sout !== 1'b1) begin bad++; $display("[TB] FAIL reset_sout_gal got=%b want=1", sout); end
  endtask

  task automatic test_fib_seq;
    logic [7:0] expq [4] = '{8'h02, 8'h04, 8'h08, 8'h11};
    logic [7:0] cur;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    total++; if (q !== 8'h01) begin bad++; $display("[TB] FAIL fib_start got=%h want=01", q); end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      cur = expq[i];
      total++; if (q !== cur) begin bad++; $display("[TB] FAIL fib_q%0d got=%h want=%h", i, q, cur); end
      total++; if (sout !== cur[7]) begin bad++; $display("[TB] FAIL fib_sout%0d got=%b want=%b", i, sout, cur[7]); end
    end
  endtask

  task automatic test_gal_seq;
    tick(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    total++; if (q !== 8'h01 || sout !== 1'b1) begin
      bad++; $display("[TB] FAIL gal_start got q=%h sout=%b want 01/1", q, sout);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    total++; if (q !== 8'hB8 || sout !== 1'b0) begin
      bad++; $display("[TB] FAIL gal_step1 got q=%h sout=%b want B8/0", q, sout);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    total++; if (q !== 8'h5C || sout !== 1'b0) begin
      bad++; $display("[TB] FAIL gal_step2 got q=%h sout=%b want 5C/0", q, sout);
    end
  endtask

  task automatic test_wrap_95;
    logic expW;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h95);
    total++; if (q !== 8'h95) begin bad++; $display("[TB] FAIL wrap95_load got=%h want=95", q); end
    for (int s = 1; s <= 510; s++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      expW = (s % 255 == 0);
      total++; if (wrap !== expW) begin bad++; $display("[TB] FAIL wrap95_pulse step=%0d got=%b want=%b", s, wrap, expW); end
      if (s == 254) begin
        total++; if (period !== 16'd0) begin bad++; $display("[TB] FAIL wrap95_preperiod got=%0d want=0", period); end
      end
      if (expW) begin
        total++; if (q !== 8'h95 || period !== 16'd255) begin
          bad++; $display("[TB] FAIL wrap95_value step=%0d got q=%h period=%0d want 95/255", s, q, period);
        end
      end
    end
  endtask

  task automatic test_lockup;
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    total++; if (q !== 8'h00 || lockup !== 1'b0) begin
      bad++; $display("[TB] FAIL lock_load got q=%h lockup=%b want 00/0", q, lockup);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    total++; if (q !== 8'h00) begin bad++; $display("[TB] FAIL lock_hold got=%h want=00", q); end
    tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    total++; if (q !== 8'h01 || lockup !== 1'b1) begin
      bad++; $display("[TB] FAIL lock_reseed got q=%h lockup=%b want 01/1", q, lockup);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    total++; if (q !== 8'h02 || lockup !== 1'b0) begin
      bad++; $display("[TB] FAIL lock_after got q=%h lockup=%b want 02/0", q, lockup);
    end
    for (int s = 2; s <= 255; s++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      if (s == 255) begin
        total++; if (wrap !== 1'b1 || q !== 8'h01 || period !== 16'd255) begin
          bad++; $display("[TB] FAIL lock_restart got wrap=%b q=%h period=%0d want 1/01/255", wrap, q, period);
        end
      end else if (wrap !== 1'b0) begin
        total++; bad++;
        $display("[TB] FAIL lock_early_wrap step=%0d got=1 want=0", s);
      end
    end
  endtask

  task automatic test_load_toggle;
    logic [7:0] tq;
    logic [7:0] walk;
    int         len;
    logic       expW;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 8'h3C);
    total++; if (q !== 8'h3C || wrap !== 1'b0) begin
      bad++; $display("[TB] FAIL ld_step got q=%h wrap=%b want 3C/0", q, wrap);
    end
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    tq   = mq;
    walk = tq;
    len  = 0;
    do begin
      walk = refNext(walk, 1'b1);
      len++;
    end while (walk != tq && len < 600);
    for (int k = 1; k <= len; k++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      expW = (k == len);
      total++; if (wrap !== expW) begin bad++; $display("[TB] FAIL toggle_wrap step=%0d got=%b want=%b", k, wrap, expW); end
      if (k == len - 1) begin
        total++; if (period !== 16'd0) begin bad++; $display("[TB] FAIL toggle_hold got=%0d want=0", period); end
      end
      if (expW) begin
        total++; if (q !== tq || period !== 16'(len)) begin
          bad++; $display("[TB] FAIL toggle_value got q=%h period=%0d want %h/%0d", q, period, tq, len);
        end
      end
    end
  endtask

  task automatic test_reset_during_wrap;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h95);
    for (int s = 1; s <= 255; s++) tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    total++; if (wrap !== 1'b1) begin bad++; $display("[TB] FAIL rstwrap_pre got=%b want=1", wrap); end
    tick(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    total++; if (wrap !== 1'b0 || period !== 16'd0 || q !== 8'h01) begin
      bad++; $display("[TB] FAIL rstwrap_post got wrap=%b period=%0d q=%h want 0/0/01", wrap, period, q);
    end
    tick(1'b1, 1'b1, 1'b1, 1'b0, 8'hAA);
    total++; if (q !== 8'h01) begin bad++; $display("[TB] FAIL rst_over_load got=%h want=01", q); end
  endtask

  task automatic test_random;
    logic rst, l, e, md;
    logic [7:0] r;
    logic expS;
    md = 1'b0;
    tick(1'b1, 1'b0, 1'b0, md, 8'h00);
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      l   = ($urandom_range(0, 199) == 0);
      e   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 79) == 0) md = ~md;
      r   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      tick(rst, l, e, md, r);
      expS = md ? mq[0] : mq[7];
      total++;
      if (q !== mq || lockup !== mlock || wrap !== mwrap || period !== 16'(mper) || sout !== expS) begin
        bad++;
        $display("[TB] FAIL random cyc=%0d got q=%h lk=%b wr=%b per=%0d so=%b want q=%h lk=%b wr=%b per=%0d so=%b",
                 c, q, lockup, wrap, period, sout, mq, mlock, mwrap, mper, expS);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    L     = 1'b0;
    E     = 1'b0;
    mode  = 1'b0;
    R     = 8'h00;
    mprev = 1'b0;
    test_reset();
    test_fib_seq();
    test_gal_seq();
    test_wrap_95();
    test_lockup();
    test_load_toggle();
    test_reset_during_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_param.md
LFSR_PARAM -- requirements
Module: lfsr_param

Interface
REQ-001 Parameter WIDTH, default 8, register width; legal range 3..32.
REQ-002 Parameter TAPS, default 8'hB8, WIDTH-bit feedback/toggle mask (bit i selects q[i]).
REQ-003 Parameter SEED, default 8'h01, WIDTH-bit reset/reseed value; must be nonzero.
REQ-004 Parameter CW, default 16, period-counter width; legal range 8..32.
REQ-005 One clock; reset is synchronous and active-high; ports are named clock and reset.
REQ-006 clock  in  1  rising-edge clock for all state.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 R  in  WIDTH  parallel load value.
REQ-009 L  in  1  load strobe; q takes R at the next edge.
REQ-010 E  in  1  step enable; one LFSR step per enabled edge.
REQ-011 mode  in  1  0 = Fibonacci, 1 = Galois.
REQ-012 q  out  WIDTH  current register state.
REQ-013 sout  out  1  serial output bit, combinational from q and mode.
REQ-014 lockup  out  1  one-cycle pulse on an all-zero reseed.
REQ-015 wrap  out  1  one-cycle pulse when the sequence returns to its reference value.
REQ-016 period  out  CW  step count of the last completed cycle.

Function
REQ-017 Priority at each edge SHALL be reset > L > E; with none asserted, all state holds.
REQ-018 Fibonacci step SHALL be: fb = XOR of q[i] over set TAPS[i]; q_next = {q[WIDTH-2:0], fb}; sout = q[WIDTH-1].
REQ-019 Galois step SHALL be: q_next = (q >> 1) XOR (q[0] ? TAPS : 0); sout = q[0].
REQ-020 L=1 SHALL load q=R, set ref=R, clear the step counter, and suppress any step that cycle, including when L and E are both 1.
REQ-021 L=1 with R=0 SHALL be accepted; q=0 holds until the next enabled step.
REQ-022 E=1 with q=0 SHALL load q=SEED, set ref=SEED, clear the step counter and pulse lockup on the following cycle instead of stepping.
REQ-023 Each normal enabled step SHALL increment the step counter, saturating at all-ones.
REQ-024 When an enabled step produces q_next==ref, wrap SHALL pulse the next cycle, period SHALL take counter+1 (saturated), and the counter SHALL restart at 0.
REQ-025 A change of mode between consecutive edges, with L=0, SHALL set ref to the current q and clear the counter; the new mode applies from that edge.
REQ-026 period SHALL hold its last value until the next wrap or reset.
REQ-027 lockup and wrap SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-028 On reset=1, the next edge SHALL set q=SEED, ref=SEED, counter=0, period=0, lockup=0, wrap=0, and the mode history register to the current mode.
REQ-029 Reset asserted mid-sequence SHALL discard pending wrap/lockup pulses and override L and E on the same edge.

Structure
REQ-030 Package lfsr_pkg SHALL hold the mode encodings (MODE_FIB=0, MODE_GAL=1) and the default TAPS/SEED constants for widths 8 and 16.
REQ-031 The combinational next-state and sout function SHALL be a sub-module lfsr_next (inputs q, mode; outputs q_next, sout; parameters WIDTH, TAPS).
REQ-032 All outputs except sout SHALL be registered.

Verification
REQ-033 Reset, then mode=0, E=1 -> q = 01, 02, 04, 08, 11 on successive edges; sout follows q[7].
REQ-034 Reset, then mode=1, E=1 -> q = 01, B8, 5C on successive edges; sout follows q[0].
REQ-035 Reset; L=1 with R=8'h95 for one cycle, then E=1 in Fibonacci mode for 255 steps -> wrap pulses once with q=95 and period=255; repeats every 255 steps.
REQ-036 L=1 with R=0, then E=1 -> q stays 00 for one cycle, lockup pulses once, q=01, and the counter restarts.
REQ-037 L=1 and E=1 on the same edge with R=8'h3C -> q=3C with no step taken; toggling mode mid-run -> no wrap until the sequence returns to the q value at the toggle.
REQ-038 Reset asserted during a wrap cycle -> wrap=0, period=0 and q=01 on the next edge.
